// File: rtl/ym09_pkg.sv
// Shared definitions for the YM bus controller: FSM states and default timing.
// Poll states exist only when YM_BUSY_POLL_EN is defined.
package ym09_pkg;

    localparam int unsigned DEF_SETUP_PM   = 1;
    localparam int unsigned DEF_STROBE_PM  = 2;
    localparam int unsigned DEF_HOLD_PM    = 1;
    localparam int unsigned DEF_RECOVER_PM = 4;
    localparam int unsigned POLL_MAX       = 255;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRecover
`ifdef YM_BUSY_POLL_EN
        ,
        StPollSetup,
        StPollStrobe,
        StPollHold
`endif
    } state_t;

    // A zero phase length would stall the FSM, so it is treated as one edge.
    function automatic logic [7:0] eff_count(input int unsigned v);
        if (v == 0) begin
            return 8'd1;
        end else if (v > 255) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/ym_pm_edge.sv
// Rising-edge detector for the phi-M clock, sampled in the clk domain.
module ym_pm_edge (
    input  logic clk,
    input  logic rst,
    input  logic ym_pm,
    output logic pm_rise
);

    logic pm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_q <= 1'b0;
        end else begin
            pm_q <= ym_pm;
        end
    end

    assign pm_rise = ym_pm & ~pm_q;

endmodule

// File: rtl/ym_bus_ctrl.sv
// YM-series chip bus cycle controller; all phase timing counts phi-M rising edges.
// Define YM_BUSY_POLL_EN to poll the status busy bit before every a0=1 write.
module ym_bus_ctrl
    import ym09_pkg::*;
#(
    parameter int unsigned SETUP_PM   = DEF_SETUP_PM,
    parameter int unsigned STROBE_PM  = DEF_STROBE_PM,
    parameter int unsigned HOLD_PM    = DEF_HOLD_PM,
    parameter int unsigned RECOVER_PM = DEF_RECOVER_PM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ym_pm,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    output logic       ym_rd_n,
    output logic       ym_a0,
    output logic [7:0] ym_dout,
    output logic       ym_dout_oe,
    input  logic [7:0] ym_din,
    output logic       busy
`ifdef YM_BUSY_POLL_EN
    ,
    output logic       poll_timeout
`endif
);

    localparam logic [7:0] SETUP_LIM   = eff_count(SETUP_PM);
    localparam logic [7:0] STROBE_LIM  = eff_count(STROBE_PM);
    localparam logic [7:0] HOLD_LIM    = eff_count(HOLD_PM);
    localparam logic [7:0] RECOVER_LIM = eff_count(RECOVER_PM);

    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic [7:0] limit;
    logic       pm_rise;
    logic       step_done;
    logic       accept;
    logic       armed_q;
    logic       wr_q, a0_q;
    logic [7:0] data_q;
    logic [7:0] rsp_data_q;
    logic       rsp_valid_q;
    logic       cs_active, poll_active;

    ym_pm_edge u_pm_edge (
        .clk     (clk),
        .rst     (rst),
        .ym_pm   (ym_pm),
        .pm_rise (pm_rise)
    );

    assign req_ready = (state_q == StIdle) && armed_q;
    assign accept    = req_valid && req_ready;

    always_comb begin
        limit = SETUP_LIM;
        case (state_q)
            StSetup:      limit = SETUP_LIM;
            StStrobe:     limit = STROBE_LIM;
            StHold:       limit = HOLD_LIM;
            StRecover:    limit = RECOVER_LIM;
`ifdef YM_BUSY_POLL_EN
            StPollSetup:  limit = SETUP_LIM;
            StPollStrobe: limit = STROBE_LIM;
            StPollHold:   limit = HOLD_LIM;
`endif
            default:      limit = SETUP_LIM;
        endcase
    end

    assign step_done = pm_rise && (({1'b0, cnt_q} + 9'd1) >= {1'b0, limit});

`ifdef YM_BUSY_POLL_EN
    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

    logic       st_bit_q;
    logic [7:0] poll_cnt_q;
    logic       timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_bit_q   <= 1'b0;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (accept) begin
                poll_cnt_q <= '0;
            end
            if (state_q == StPollStrobe && state_d == StPollHold) begin
                st_bit_q <= ym_din[7];
            end
            if (state_q == StPollHold && step_done && st_bit_q) begin
                poll_cnt_q <= poll_cnt_q + 8'd1;
                if (poll_cnt_q == POLL_LAST) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign poll_timeout = timeout_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef YM_BUSY_POLL_EN
                    state_d = (req_wr && req_a0) ? StPollSetup : StSetup;
`else
                    state_d = StSetup;
`endif
                end
            end
            StSetup:   if (step_done) state_d = StStrobe;
            StStrobe:  if (step_done) state_d = StHold;
            StHold:    if (step_done) state_d = StRecover;
            StRecover: if (step_done) state_d = StIdle;
`ifdef YM_BUSY_POLL_EN
            StPollSetup:  if (step_done) state_d = StPollStrobe;
            StPollStrobe: if (step_done) state_d = StPollHold;
            StPollHold: begin
                // Give up after the last allowed busy poll and let the write go.
                if (step_done) begin
                    state_d = (st_bit_q && poll_cnt_q != POLL_LAST) ? StPollSetup : StSetup;
                end
            end
`endif
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            wr_q        <= 1'b0;
            a0_q        <= 1'b0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (state_d != state_q || state_q == StIdle) begin
                cnt_q <= '0;
            end else if (pm_rise) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (accept) begin
                wr_q   <= req_wr;
                a0_q   <= req_a0;
                data_q <= req_data;
            end
            if (state_q == StStrobe && state_d == StHold && !wr_q) begin
                rsp_data_q  <= ym_din;
                rsp_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cs_active   = 1'b0;
        poll_active = 1'b0;
        unique case (state_q)
            StSetup, StStrobe, StHold: cs_active = 1'b1;
`ifdef YM_BUSY_POLL_EN
            StPollSetup, StPollStrobe, StPollHold: begin
                cs_active   = 1'b1;
                poll_active = 1'b1;
            end
`endif
            default: cs_active = 1'b0;
        endcase
    end

    assign ym_cs_n    = ~cs_active;
    assign ym_wr_n    = ~((state_q == StStrobe) && wr_q);
`ifdef YM_BUSY_POLL_EN
    assign ym_rd_n    = ~(((state_q == StStrobe) && !wr_q) || (state_q == StPollStrobe));
`else
    assign ym_rd_n    = ~((state_q == StStrobe) && !wr_q);
`endif
    assign ym_a0      = cs_active && !poll_active && a0_q;
    assign ym_dout    = data_q;
    assign ym_dout_oe = cs_active && !poll_active && wr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ym_bus_ctrl.sv
// Scoreboard bench for ym_bus_ctrl: random host traffic, bus-cycle timing measured in phi-M edges.
module tb_ym_bus_ctrl;

    localparam int unsigned SETUP_PM   = 1;
    localparam int unsigned STROBE_PM  = 2;
    localparam int unsigned HOLD_PM    = 1;
    localparam int unsigned RECOVER_PM = 4;
    localparam int CYC_RISES = SETUP_PM + STROBE_PM + HOLD_PM;

    typedef struct packed {
        logic       wr;
        logic       a0;
        logic [7:0] data;
    } tx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ym_pm = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic       req_a0 = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic [7:0] ym_din = 8'h00;
    logic       stall = 1'b0;

    logic       req_ready, rsp_valid, ym_cs_n, ym_wr_n, ym_rd_n, ym_a0, ym_dout_oe, busy;
    logic [7:0] rsp_data, ym_dout;
`ifdef YM_BUSY_POLL_EN
    logic       poll_timeout;
`endif

    int total = 0;
    int bad = 0;
    tx_t        txq[$];
    logic [7:0] rspq[$];

    ym_bus_ctrl #(
        .SETUP_PM   (SETUP_PM),
        .STROBE_PM  (STROBE_PM),
        .HOLD_PM    (HOLD_PM),
        .RECOVER_PM (RECOVER_PM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ym_pm      (ym_pm),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_a0     (req_a0),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .ym_cs_n    (ym_cs_n),
        .ym_wr_n    (ym_wr_n),
        .ym_rd_n    (ym_rd_n),
        .ym_a0      (ym_a0),
        .ym_dout    (ym_dout),
        .ym_dout_oe (ym_dout_oe),
        .ym_din     (ym_din),
        .busy       (busy)
`ifdef YM_BUSY_POLL_EN
        ,
        .poll_timeout (poll_timeout)
`endif
    );

    always #5 clk = ~clk;

    // phi-M: period 5 clk (2 high, 3 low); stall freezes it low without losing phase.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!stall) ph = (ph + 1) % 5;
            ym_pm = stall ? 1'b0 : (ph < 2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cs_n", ym_cs_n, 1);
        check("rst_wr_n", ym_wr_n, 1);
        check("rst_rd_n", ym_rd_n, 1);
        check("rst_a0", ym_a0, 0);
        check("rst_dout", ym_dout, 0);
        check("rst_dout_oe", ym_dout_oe, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
    endtask

    task automatic issue(input logic wr, input logic a0, input logic [7:0] d,
                         input logic [7:0] din, input int extra);
        int n;
        @(negedge clk);
        if (!busy) ym_din = din;
        req_valid = 1'b1;
        req_wr    = wr;
        req_a0    = a0;
        req_data  = d;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_budget", req_ready, 1);
        if (req_ready) begin
            @(posedge clk);
            txq.push_back('{wr: wr, a0: a0, data: d});
            if (!wr) rspq.push_back(ym_din);
            #1;
            // Holding valid while busy must not queue a second request.
            repeat (extra) @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_budget", busy, 0);
    endtask

    // Bus monitor: pops one expected transaction per cs_n low window.
    initial begin
        logic prev_pm, prev_cs, in_cyc, have_prev, fields_ok, saw_wr, saw_rd, rise;
        int   cyc_r, wr_r, rd_r, rec_r;
        tx_t  cur;
        prev_pm = 0; prev_cs = 1; in_cyc = 0; have_prev = 0; fields_ok = 1;
        saw_wr = 0; saw_rd = 0; cyc_r = 0; wr_r = 0; rd_r = 0; rec_r = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pm = 0; prev_cs = 1; in_cyc = 0; have_prev = 0;
                continue;
            end
            rise = ym_pm && !prev_pm;
            prev_pm = ym_pm;
            total++;
            if ((!ym_wr_n && !ym_rd_n) || ((!ym_wr_n || !ym_rd_n) && ym_cs_n) ||
                (req_ready && busy) || (!ym_cs_n && !busy)) begin
                bad++;
                $display("FAIL bus_invariant: cs_n=%b wr_n=%b rd_n=%b ready=%b busy=%b",
                         ym_cs_n, ym_wr_n, ym_rd_n, req_ready, busy);
            end
            if (!ym_cs_n && prev_cs) begin
                check("cycle_expected", txq.size() != 0, 1);
                cur = (txq.size() != 0) ? txq.pop_front() : '0;
                if (have_prev) check("recover_rises_min", rec_r >= RECOVER_PM, 1);
                in_cyc = 1; cyc_r = 0; wr_r = 0; rd_r = 0;
                fields_ok = 1; saw_wr = 0; saw_rd = 0;
            end
            if (!ym_cs_n) begin
                if (rise) cyc_r++;
                if (!ym_wr_n) begin saw_wr = 1; if (rise) wr_r++; end
                if (!ym_rd_n) begin saw_rd = 1; if (rise) rd_r++; end
                if (ym_a0 !== cur.a0 || ym_dout_oe !== cur.wr || (cur.wr && ym_dout !== cur.data))
                    fields_ok = 0;
            end else begin
                if (!prev_cs && in_cyc) begin
                    check("cs_low_rises", cyc_r, CYC_RISES);
                    check("strobe_rises", cur.wr ? wr_r : rd_r, STROBE_PM);
                    check("wrong_strobe_seen", cur.wr ? saw_rd : saw_wr, 0);
                    check("strobe_seen", cur.wr ? saw_wr : saw_rd, 1);
                    check("cycle_fields", fields_ok, 1);
                    in_cyc = 0; have_prev = 1; rec_r = 0;
                end
                if (have_prev && rise) rec_r++;
            end
            prev_cs = ym_cs_n;
        end
    end

    // Response monitor.
    initial begin
        logic prev;
        logic [7:0] exp;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
                continue;
            end
            if (rsp_valid) begin
                check("rsp_single_pulse", prev, 0);
                check("rsp_expected", rspq.size() != 0, 1);
                if (rspq.size() != 0) begin
                    exp = rspq.pop_front();
                    check("rsp_data", rsp_data, exp);
                end
            end
            prev = rsp_valid;
        end
    end

    initial begin
        int n;
        logic ok;
        #12;
        check_reset_outputs();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("ready_before_first_clk", req_ready, 0);
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        // Directed: write a0=1 0x5A, then read a0=0 with status 0x80.
        issue(1'b1, 1'b1, 8'h5A, 8'h00, 0);
        wait_idle();
        issue(1'b0, 1'b0, 8'h00, 8'h80, 0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("read_data_0x80", rsp_data, 8'h80);
        issue(1'b1, 1'b0, 8'h11, 8'h33, 3);
        wait_idle();
        check("rsp_data_held", rsp_data, 8'h80);

        // Back-to-back requests with valid held over the busy period.
        issue(1'b1, 1'b0, 8'hA5, 8'h00, 5);
        issue(1'b0, 1'b1, 8'h00, 8'h00, 5);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  8'($urandom), $urandom_range(0, 5));
            if ($urandom_range(0, 2) != 0) begin
                wait_idle();
                repeat ($urandom_range(0, 7)) @(negedge clk);
            end
        end
        wait_idle();

        // phi-M stuck low for 100 clk in SETUP.
        issue(1'b1, 1'b1, 8'hC3, 8'h00, 0);
        stall = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!(ym_cs_n == 0 && ym_wr_n == 1 && ym_rd_n == 1 && busy && ym_dout_oe &&
                  ym_dout == 8'hC3 && ym_a0)) ok = 1'b0;
        end
        check("stall_frozen", ok, 1);
        stall = 1'b0;
        wait_idle();

        // Reset in the middle of a read strobe.
        issue(1'b0, 1'b1, 8'h00, 8'h5C, 0);
        n = 0;
        while (ym_rd_n && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_strobe", ym_rd_n, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        txq.delete();
        rspq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("ready_before_first_clk2", req_ready, 0);
        @(negedge clk);
        check("ready_after_release2", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  8'($urandom), $urandom_range(0, 5));
            wait_idle();
        end

        n = 0;
        while (rspq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("rsp_queue_drained", rspq.size(), 0);
        check("tx_queue_drained", txq.size(), 0);
`ifdef YM_BUSY_POLL_EN
        check("poll_timeout_clear", poll_timeout, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
